qmult_rr_sched: RTL and testbench
=================================

// Module: qmult_rr_sched
// PURPOSE
//   Round-robin scheduler sharing one signed-magnitude Q-format fixed-point multiplier among
//   NREQ requesters in the IPGU datapath. Accepts operand pairs over per-requester valid/ready,
//   performs a registered multiply, returns result + overflow + requester ID over one response port.
//   One transaction in flight at a time.
// PARAMETERS
//   NREQ  4   number of requesters (>=2)
//   N     32  operand/result width, bit N-1 = sign, bits N-2:0 = magnitude
//   Q     15  fractional bits (Q < N-1)
// PORTS
//   clk         in   1            clock; all logic on rising edge
//   rst         in   1            synchronous active-high reset
//   req_valid   in   NREQ         requester i has an operand pair
//   req_ready   out  NREQ         one-hot accept; handshake when valid&ready
//   req_a       in   NREQ*N       multiplicands, requester i at [i*N +: N]
//   req_b       in   NREQ*N       multipliers, requester i at [i*N +: N]
//   rsp_valid   out  1            response available
//   rsp_ready   in   1            consumer accepts response
//   rsp_id      out  clog2(NREQ)  requester index of response
//   rsp_result  out  N            signed-magnitude Q product
//   rsp_ovr     out  1            integer-part overflow of this product
//   busy        out  1            state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, rr pointer=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_ovr=0, busy=0,
//     req_ready=0. Reset in any state drops the in-flight transaction; no response emitted.
//   - FSM IDLE -> MUL -> RSP -> IDLE.
//   - IDLE: grant g = first i with req_valid[i] searching from pointer upward, wrapping at NREQ.
//     req_ready[g]=1 combinationally that cycle (all others 0); latch a,b,g; go MUL. No valid: stay.
//   - MUL (1 cycle): mag = a[N-2:0]*b[N-2:0] (2N-2 bits, unsigned); register
//     rsp_result[N-1] = a[N-1]^b[N-1] (kept even if magnitude 0), rsp_result[N-2:0] = mag[N-2+Q:Q]
//     (truncation, no rounding), rsp_ovr = |mag[2N-3:N-1+Q]; rsp_id=g; go RSP.
//   - RSP: rsp_valid=1, outputs held stable until rsp_ready=1; on handshake rsp_valid=0 next
//     cycle, pointer = (g+1) mod NREQ, go IDLE.
//   - req_ready is 0 in MUL and RSP; new requests wait. No grant in the same cycle as RSP handshake.
//   - Latency: accept at cycle t -> rsp_valid at t+2. Peak throughput 1 per 3 cycles.
//   - req_valid dropped before grant: requester simply not granted; no state change.
//   - rsp_* outputs outside RSP retain last value (don't-care to consumer).
// CONFIGURATION
//   QMULT_SAT_EN defined: when overflow detected, rsp_result[N-2:0] = all ones (max magnitude),
//     sign unchanged; rsp_ovr still 1.
//   Not defined: overflowed result is the truncated slice mag[N-2+Q:Q]; rsp_ovr=1.
// TESTING  (N=32, Q=15, NREQ=4)
//   1. req0 a=0x0000C000 (1.5), b=0x00010000 (2.0), rsp_ready=1 -> rsp_valid at t+2,
//      rsp_result=0x00018000, rsp_ovr=0, rsp_id=0.
//   2. req2 a=0x8000C000 (-1.5), b=0x00010000 -> rsp_result=0x80018000, rsp_ovr=0, rsp_id=2;
//      a=0x80000000, b=0x00008000 -> rsp_result=0x80000000.
//   3. req1 a=0x40000000, b=0x00010000 -> rsp_ovr=1, rsp_result=0x00000000;
//      with QMULT_SAT_EN -> rsp_result=0x7FFFFFFF.
//   4. All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each req_ready one-hot
//      single cycle, 3 cycles apart.
//   5. rsp_ready=0 for 5 cycles in RSP -> rsp_valid, rsp_result, rsp_id stable; req_ready all 0;
//      rsp_ready=1 -> back to IDLE, next grant 2 cycles later.
//   6. rst=1 for one cycle while in MUL after granting req3 -> next cycle busy=0, rsp_valid=0;
//      with req0 and req3 valid, next grant goes to req0.

Source files
------------

// File: rtl/qmult_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : qmult_rr_sched
// Brief    : Round-robin scheduler sharing one signed-magnitude Q multiplier
//            among NREQ requesters; one transaction in flight at a time.
//            Optional saturation on overflow: define QMULT_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module qmult_rr_sched #(
    parameter int NREQ = 4,
    parameter int N    = 32,
    parameter int Q    = 15,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_result,
    output logic              rsp_ovr,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [IDW-1:0] g_q;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [2*N-3:0] mag;
    logic [N-2:0]   mag_trunc;
    logic [N-2:0]   res_mag;
    logic           ovr;

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign mag       = {{(N-1){1'b0}}, a_q[N-2:0]} * {{(N-1){1'b0}}, b_q[N-2:0]};
    assign mag_trunc = (N-1)'(mag >> Q);
    assign ovr       = |(mag >> (N - 1 + Q));

`ifdef QMULT_SAT_EN
    assign res_mag = ovr ? {(N-1){1'b1}} : mag_trunc;
`else
    assign res_mag = mag_trunc;
`endif

    assign ptr_nxt = (g_q == IDW'(NREQ - 1)) ? '0 : g_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found) state_nxt = S_MUL;
            S_MUL:   state_nxt = S_RSP;
            S_RSP:   if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        req_ready = '0;
        if (state == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            g_q        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_ovr    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        a_q <= req_a[int'(grant_idx) * N +: N];
                        b_q <= req_b[int'(grant_idx) * N +: N];
                        g_q <= grant_idx;
                    end
                end
                S_MUL: begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= {a_q[N-1] ^ b_q[N-1], res_mag};
                    rsp_ovr    <= ovr;
                    rsp_id     <= g_q;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qmult_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_qmult_rr_sched
// Brief    : Directed self-checking bench for qmult_rr_sched (N=32,Q=15,NREQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qmult_rr_sched;

    localparam int NREQ = 4;
    localparam int N    = 32;
    localparam int Q    = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [N-1:0]      rsp_result;
    logic              rsp_ovr;
    logic              busy;

    int passed = 0;
    int total  = 0;

    qmult_rr_sched #(.NREQ(NREQ), .N(N), .Q(Q)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ovr(rsp_ovr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
        $fatal(1);
    end

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Stimulus only: issue one transaction and collect the response fields.
    task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic ovr,
                           output logic [1:0] rid, output int lat);
        lat = -1;
        req_valid        = '0;
        req_valid[id]    = 1'b1;
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
        rsp_ready        = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[id]) break;
        end
        @(posedge clk);
        #1 req_valid = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        res = rsp_result;
        ovr = rsp_ovr;
        rid = rsp_id;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            $display("FAIL reset_ctrl: busy=%b rsp_valid=%b req_ready=%b required 0 0 0000",
                     busy, rsp_valid, req_ready);
        end else passed++;
        total++;
        if (rsp_id !== 2'd0 || rsp_result !== 32'h0 || rsp_ovr !== 1'b0) begin
            $display("FAIL reset_rsp: id=%0d result=%h ovr=%b required 0 00000000 0",
                     rsp_id, rsp_result, rsp_ovr);
        end else passed++;
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] res; logic ovr; logic [1:0] rid; int lat;
        apply_reset();
        run_one(0, 32'h0000C000, 32'h00010000, res, ovr, rid, lat);
        total++;
        if (lat !== 2) $display("FAIL basic_latency: got %0d required 2", lat);
        else passed++;
        total++;
        if (res !== 32'h00018000 || ovr !== 1'b0 || rid !== 2'd0) begin
            $display("FAIL basic_1p5x2: result=%h ovr=%b id=%0d required 00018000 0 0", res, ovr, rid);
        end else passed++;
        run_one(1, 32'h00008000, 32'h00008000, res, ovr, rid, lat);
        total++;
        if (res !== 32'h00008000 || ovr !== 1'b0 || rid !== 2'd1) begin
            $display("FAIL basic_1x1: result=%h ovr=%b id=%0d required 00008000 0 1", res, ovr, rid);
        end else passed++;
        run_one(3, 32'h80000001, 32'h80000001, res, ovr, rid, lat);
        total++;
        if (res !== 32'h00000000 || ovr !== 1'b0 || rid !== 2'd3) begin
            $display("FAIL basic_trunc: result=%h ovr=%b id=%0d required 00000000 0 3", res, ovr, rid);
        end else passed++;
    endtask

    task automatic test_sign();
        logic [31:0] res; logic ovr; logic [1:0] rid; int lat;
        apply_reset();
        run_one(2, 32'h8000C000, 32'h00010000, res, ovr, rid, lat);
        total++;
        if (res !== 32'h80018000 || ovr !== 1'b0 || rid !== 2'd2) begin
            $display("FAIL sign_neg: result=%h ovr=%b id=%0d required 80018000 0 2", res, ovr, rid);
        end else passed++;
        run_one(2, 32'h80000000, 32'h00008000, res, ovr, rid, lat);
        total++;
        if (res !== 32'h80000000 || ovr !== 1'b0) begin
            $display("FAIL sign_negzero: result=%h ovr=%b required 80000000 0", res, ovr);
        end else passed++;
    endtask

    task automatic test_overflow();
        logic [31:0] res; logic ovr; logic [1:0] rid; int lat;
        logic [31:0] exp_res;
`ifdef QMULT_SAT_EN
        exp_res = 32'h7FFFFFFF;
`else
        exp_res = 32'h00000000;
`endif
        apply_reset();
        run_one(1, 32'h40000000, 32'h00010000, res, ovr, rid, lat);
        total++;
        if (res !== exp_res || ovr !== 1'b1 || rid !== 2'd1) begin
            $display("FAIL overflow: result=%h ovr=%b id=%0d required %h 1 1", res, ovr, rid, exp_res);
        end else passed++;
        run_one(0, 32'h00007FFF, 32'h00007FFF, res, ovr, rid, lat);
        total++;
        if (res !== 32'h00007FFE || ovr !== 1'b0) begin
            $display("FAIL no_overflow_edge: result=%h ovr=%b required 00007ffe 0", res, ovr);
        end else passed++;
    endtask

    task automatic test_rr_order();
        logic [3:0] exp_rdy;
        int errs;
        apply_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        errs = 0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            exp_rdy = (k % 3 == 0) ? 4'(1 << ((k / 3) % 4)) : 4'b0000;
            if (req_ready !== exp_rdy) begin
                $display("FAIL rr_order cycle %0d: req_ready=%b required %b", k, req_ready, exp_rdy);
                errs++;
            end
        end
        total++;
        if (errs == 0) passed++;
        @(posedge clk);
        #1 req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [31:0] cap_res;
        int errs;
        apply_reset();
        req_valid        = 4'b0010;
        req_a[1*N +: N]  = 32'h0000C000;
        req_b[1*N +: N]  = 32'h00010000;
        rsp_ready        = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[1]) break;
        end
        @(posedge clk);
        #1 req_valid = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        cap_res = rsp_result;
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h00018000 || rsp_id !== 2'd1 ||
                rsp_result !== cap_res || req_ready !== 4'b0000) begin
                $display("FAIL bp_hold cycle %0d: valid=%b result=%h id=%0d req_ready=%b required 1 00018000 1 0000",
                         k, rsp_valid, rsp_result, rsp_id, req_ready);
                errs++;
            end
        end
        total++;
        if (errs == 0) passed++;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
            $display("FAIL bp_handshake_cycle: valid=%b req_ready=%b required 1 0000", rsp_valid, req_ready);
        end else passed++;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0100 || busy !== 1'b0) begin
            $display("FAIL bp_next_grant: valid=%b req_ready=%b busy=%b required 0 0100 0",
                     rsp_valid, req_ready, busy);
        end else passed++;
        @(posedge clk);
        #1 req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[3]) break;
        end
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) $display("FAIL midflight_in_mul: busy=%b required 1", busy);
        else passed++;
        rst       = 1'b1;
        req_valid = 4'b1001;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
            $display("FAIL midflight_reset: busy=%b rsp_valid=%b req_ready=%b required 0 0 0001",
                     busy, rsp_valid, req_ready);
        end else passed++;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_overflow();
        test_rr_order();
        test_backpressure();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
